// File: rtl/bit_packer.sv
// bit_packer: packs 1..W-bit fields MSB-first into W-bit words,
// with valid/ready on both sides and a flush that emits a left-aligned tail.
module bit_packer #(
  parameter int W  = 32,
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [LW-1:0] in_len,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] out_bits,
  output logic [LW-1:0] level,
  output logic          busy
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [LW-1:0] WL = LW'(W);

  state_t         state;
  logic [2*W-1:0] acc;
  logic [LW-1:0]  len;
  logic [W-1:0]   mask;
  logic [W-1:0]   full_word;
  logic [W-1:0]   part_word;
  logic           out_free;
  logic           accept;
  logic           emit;
  logic           partial;

  always_comb begin
    len  = (in_len > WL) ? WL : in_len;
    // shifting by W yields zero, so mask(W) is all ones
    mask = ~({W{1'b1}} << len);
  end

  assign full_word = W'(acc >> (level - WL));
  assign part_word = W'(acc << (WL - level));

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == RUN) && (level < WL);
  assign accept   = in_valid && in_ready;
  assign emit     = (level >= WL) && out_free;
  assign partial  = (state == FLUSH) && (level != '0) &&
                    (level < WL) && out_free;
  assign busy     = (level != '0) || out_valid || (state == FLUSH);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= RUN;
      acc       <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bits  <= '0;
    end else begin
      if (accept) begin
        acc   <= (acc << len) | {{W{1'b0}}, in_data & mask};
        level <= level + len;
      end else if (emit) begin
        level <= level - WL;
      end else if (partial) begin
        level <= '0;
      end

      if (emit || partial) begin
        out_valid <= 1'b1;
        out_data  <= emit ? full_word : part_word;
        out_bits  <= emit ? WL : level;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        RUN:
          if (flush) state <= FLUSH;
        FLUSH:
          if (level < WL && (level == '0 || out_free))
            state <= RUN;
        default:
          state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: directed and random checks of bit_packer against
// a bit-queue reference model of the packed stream.
module tb_bit_packer;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_bits;
  logic [5:0]  level;
  logic        busy;

  bit_packer #(.W(32), .LW(6)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bits(out_bits),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;
  int or_mode = 2;
  int nwords = 0;
  logic [31:0] last_data;
  logic [5:0]  last_bits;

  bit          q[$];
  logic [31:0] exp_d[$];
  int          exp_b[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(logic [31:0] d, int l);
    int n;
    logic [31:0] w;
    n = (l > 32) ? 32 : l;
    for (int i = n - 1; i >= 0; i--) q.push_back(d[i]);
    while (q.size() >= 32) begin
      for (int i = 31; i >= 0; i--) w[i] = q.pop_front();
      exp_d.push_back(w);
      exp_b.push_back(32);
    end
  endtask

  task automatic model_flush();
    logic [31:0] w;
    int n;
    n = q.size();
    if (n > 0) begin
      w = '0;
      for (int i = 31; i >= 32 - n; i--) w[i] = q.pop_front();
      exp_d.push_back(w);
      exp_b.push_back(n);
    end
  endtask

  // consumer side: picks out_ready, then scores each handshake
  always @(negedge clk) begin
    case (or_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    #1;
    if (clr && out_valid && out_ready) begin
      check("word_expected", 64'(exp_d.size() > 0), 64'd1);
      if (exp_d.size() > 0) begin
        check("out_data", 64'(out_data), 64'(exp_d.pop_front()));
        check("out_bits", 64'(out_bits), 64'(exp_b.pop_front()));
      end
      nwords++;
      last_data = out_data;
      last_bits = out_bits;
    end
  end

  task automatic send(logic [31:0] d, int l, bit fl);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = 6'(l);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", 64'(n < 1000), 64'd1);
    flush = fl;
    @(posedge clk);
    if (n < 1000) begin
      model_push(d, l);
      if (fl) model_flush();
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    model_flush();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n < 2000), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_cycles(int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    int nw;
    logic [31:0] held;
    logic [31:0] d;
    int l;
    bit fl;

    clr = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_len = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_bits", 64'(out_bits), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // four bytes make one word
    or_mode = 2;
    nw = nwords;
    send(32'hAA, 8, 0);
    send(32'hBB, 8, 0);
    send(32'hCC, 8, 0);
    send(32'hDD, 8, 0);
    wait_idle();
    check("t2_words", 64'(nwords - nw), 64'd1);
    check("t2_data", 64'(last_data), 64'hAABBCCDD);
    check("t2_bits", 64'(last_bits), 64'd32);
    check("t2_level", 64'(level), 64'd0);

    // 20+20 bits: one word and an 8-bit tail
    send(32'hABCDE, 20, 0);
    send(32'h12345, 20, 0);
    wait_cycles(3);
    check("t3_data", 64'(last_data), 64'hABCDE123);
    check("t3_level", 64'(level), 64'd8);
    do_flush();
    wait_idle();
    check("t3_fdata", 64'(last_data), 64'h45000000);
    check("t3_fbits", 64'(last_bits), 64'd8);
    check("t3_flevel", 64'(level), 64'd0);
    check("t3_run", 64'(in_ready), 64'd1);

    // back-pressure with two words pending
    or_mode = 1;
    @(negedge clk);
    nw = nwords;
    for (int i = 0; i < 8; i++) send($urandom, 8, 0);
    wait_cycles(3);
    check("t4_in_ready", 64'(in_ready), 64'd0);
    check("t4_level", 64'(level), 64'd32);
    check("t4_out_valid", 64'(out_valid), 64'd1);
    check("t4_head", 64'(out_data), 64'(exp_d[0]));
    held = out_data;
    wait_cycles(4);
    check("t4_stable", 64'(out_data), 64'(held));
    or_mode = 2;
    wait_idle();
    check("t4_words", 64'(nwords - nw), 64'd2);
    check("t4_drained", 64'(exp_d.size()), 64'd0);

    // len 0 is a no-op, len 40 clamps to 32
    nw = nwords;
    send(32'hFFFFFFFF, 0, 0);
    wait_cycles(2);
    check("t5_noop_level", 64'(level), 64'd0);
    send(32'hFFFFFFFF, 40, 0);
    wait_idle();
    check("t5_words", 64'(nwords - nw), 64'd1);
    check("t5_data", 64'(last_data), 64'hFFFFFFFF);
    send(32'hFFFFFFF5, 4, 0);
    do_flush();
    wait_idle();
    check("t5_mask", 64'(last_data), 64'h50000000);

    // flush with empty accumulator, then flush with a same-cycle accept
    nw = nwords;
    do_flush();
    wait_idle();
    check("t6_empty_flush", 64'(nwords - nw), 64'd0);
    send(32'h9, 4, 1);
    wait_idle();
    check("t6_data", 64'(last_data), 64'h90000000);
    check("t6_bits", 64'(last_bits), 64'd4);

    // reset mid-stream drops everything
    or_mode = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) send($urandom, 8, 0);
    #2;
    clr = 1'b0;
    #1;
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_level", 64'(level), 64'd0);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    exp_d.delete();
    exp_b.delete();
    @(negedge clk);
    clr = 1'b1;
    or_mode = 0;

    // random fields, random back-pressure, occasional flushes
    for (int i = 0; i < 200; i++) begin
      d  = $urandom;
      l  = $urandom_range(0, 40);
      fl = ($urandom_range(0, 15) == 0);
      send(d, l, fl);
      if (fl) begin
        wait_idle();
        check("rnd_level", 64'(level), 64'd0);
        check("rnd_queue", 64'(exp_d.size()), 64'd0);
      end
    end
    do_flush();
    wait_idle();
    check("end_level", 64'(level), 64'd0);
    check("end_queue", 64'(exp_d.size()), 64'd0);
    check("end_bits", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
